reg_dump_unit: RTL and testbench
================================

// Module: reg_dump_unit
// PURPOSE
//  Debug read-out engine for the LC-3 register file. On a start pulse it walks the
//  file's read-select over a range of registers and captures each read value.
//  It streams each value out as an indexed word over a valid/ready handshake.
//  Sits beside the datapath on the register file's SR1 read port. The debug
//  mux selects between reg_dump_unit and the decoder.
// PARAMETERS
//  WIDTH    16  data width of one register / output word
//  ADDR_W   3   register index width (file depth = 2**ADDR_W = 8)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset (0 = in reset)
//  start      in   1       request a dump; sampled only in IDLE
//  first_reg  in   ADDR_W  first register to dump; latched when start accepted
//  last_reg   in   ADDR_W  last register to dump; latched when start accepted
//  SR         out  ADDR_W  read select driven to register file read port
//  Rdata      in   WIDTH   combinational read data returned for SR
//  out_data   out  WIDTH   captured register value
//  out_idx    out  ADDR_W  index of register in out_data
//  out_valid  out  1       out_data/out_idx valid
//  out_ready  in   1       consumer accepts word when out_valid & out_ready
//  busy       out  1       1 in any state other than IDLE
//  done       out  1       one-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, SR=0, out_data=0, out_idx=0,
//    out_valid=0, busy=0, done=0, cur/last registers=0.
//  - States: IDLE -> READ -> SEND -> (READ | DONE) -> IDLE.
//  - IDLE: start=1 at a rising edge latches first_reg/last_reg, sets cur=first_reg,
//    and enters READ. start=0 stays IDLE.
//  - READ (1 cycle): SR=cur. The file read is combinational, so Rdata is captured
//    at the end of this cycle into out_data; out_idx<=cur. Enter SEND.
//  - SEND: out_valid=1. out_data and out_idx are held stable until handshake.
//    On out_valid&out_ready: if cur==last go DONE, else cur<=cur+1 mod 8 and go READ.
//  - DONE (1 cycle): done=1, out_valid=0; next cycle IDLE.
//  - SR holds cur in READ/SEND. SR=0 in IDLE/DONE.
//  - Range: word count = ((last-first) mod 8)+1.
//  - first==last: exactly one word.
//  - last<first wraps through 7->0 (first=6,last=1: 6,7,0,1).
//  - first=0,last=7: all 8 registers.
//  - Throughput: max one word per 2 cycles. start at edge k: first out_valid at k+2.
//    With out_ready tied 1, done at k+2N+1 for N words.
//  - start while busy (READ/SEND/DONE) is ignored; not queued.
//  - Snapshot is per register at its READ cycle, not atomic across the range.
//    A write to register r after r's READ is not reflected. A write before r's READ
//    is reflected. A same-cycle write/read returns the old value, since the file
//    writes on the edge.
//  - reset asserted mid-dump aborts immediately to reset values. No done pulse.
//  - out_ready is ignored when out_valid=0.
// TESTING
//  1. Preload R0..R7=16'h1000+i; hold reset=0 -> all outputs 0. Release, idle 5 cycles
//     -> out_valid=0, busy=0, done=0.
//  2. start at cycle 0, first=0, last=7, out_ready=1 -> words (i,16'h1000+i) for i=0..7.
//     valid at cycles 2,4,...,16; done=1 at cycle 17 only.
//  3. Same dump with out_ready toggled 0/1 randomly -> out_data/out_idx stable while
//     valid&!ready. Exactly 8 words in order; no drop or duplicate.
//  4. first=6, last=1 -> idx 6,7,0,1 with values 1006,1007,1000,1001.
//     first=first=3,last=3 -> single word 1003.
//  5. Pulse start during SEND of a 0..7 dump -> ignored. Exactly 8 words and one done.
//     Write R5=16'hBEEF during R2's SEND -> idx5 reports BEEF.
//  6. Pull reset low while in SEND of word 3 -> out_valid and busy drop asynchronously;
//     no done. After release, a new start dumps correctly from first_reg.

Source files
------------

// File: rtl/reg_dump_unit_if.sv
// ----------------------------------------------------------------------------
// reg_dump_unit_if
//   Output word stream of the register dump engine: one indexed register
//   value per transfer, moved over a valid/ready handshake.
//
//   out_data   WIDTH   captured register value
//   out_idx    ADDR_W  register index that out_data came from
//   out_valid  1       out_data/out_idx are valid
//   out_ready  1       consumer takes the word when out_valid & out_ready
//
//   master : the dump engine (drives data/idx/valid, samples ready)
//   slave  : the consumer    (drives ready, samples data/idx/valid)
// ----------------------------------------------------------------------------
interface reg_dump_unit_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_unit.sv
// ----------------------------------------------------------------------------
// reg_dump_unit
//   Debug read-out engine for the LC-3 register file. A start request in IDLE
//   latches a register range; the engine then drives the file's read select
//   (SR) one register at a time, captures the combinational read data, and
//   presents each value with its index on a valid/ready stream. A one-cycle
//   done pulse follows the last accepted word.
//
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous active-low reset
//   start      in   1       dump request, only looked at in IDLE
//   first_reg  in   ADDR_W  first register of the range (latched on start)
//   last_reg   in   ADDR_W  last register of the range (latched on start)
//   SR         out  ADDR_W  read select to the register file read port
//   Rdata      in   WIDTH   combinational read data for SR
//   busy       out  1       engine is not IDLE
//   done       out  1       one-cycle pulse after the last word is accepted
//   stream     master modport of reg_dump_unit_if (out_data/out_idx/
//                            out_valid/out_ready)
// ----------------------------------------------------------------------------
module reg_dump_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] SR,
    input  logic [WIDTH-1:0]  Rdata,
    output logic              busy,
    output logic              done,
    reg_dump_unit_if.master   stream
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_sel;
    logic              accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs. Valid, busy, done and SR are pure
    // decodes of the state register, so an asynchronous reset drops them
    // immediately without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        SR               = '0;
        busy             = 1'b1;
        done             = 1'b0;
        stream.out_valid = 1'b0;
        accept           = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                SR         = cur;
                state_next = S_SEND;
            end
            S_SEND: begin
                // SR stays on cur while the word waits for the consumer;
                // the captured value does not change because of this.
                SR               = cur;
                stream.out_valid = 1'b1;
                accept           = stream.out_ready;
                if (accept) begin
                    state_next = (cur == last_sel) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Range walker and output word capture.
    // The file read is combinational, so the value for cur is settled on
    // Rdata during READ and is captured on the edge that leaves READ. A
    // file write landing on that same edge is therefore not seen.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur             <= '0;
            last_sel        <= '0;
            stream.out_data <= '0;
            stream.out_idx  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cur      <= first_reg;
                        last_sel <= last_reg;
                    end
                end
                S_READ: begin
                    stream.out_data <= Rdata;
                    stream.out_idx  <= cur;
                end
                S_SEND: begin
                    // Index wraps modulo the file depth, so a range with
                    // last < first walks through the top register to 0.
                    if (accept && (cur != last_sel)) begin
                        cur <= cur + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// ----------------------------------------------------------------------------
// tb_reg_dump_unit
//   Directed bench for reg_dump_unit with a small behavioural register file
//   on the SR/Rdata port and a consumer on the output stream.
// ----------------------------------------------------------------------------
module tb_reg_dump_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  first_reg;
    logic [2:0]  last_reg;
    logic [2:0]  SR;
    logic [15:0] Rdata;
    logic        busy;
    logic        done;

    // register file model: combinational read, write on the rising edge
    logic [15:0] rf [8];
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;

    int checks;
    int errors;
    bit beef_written;

    reg_dump_unit_if #(.WIDTH(16), .ADDR_W(3)) stream_if ();

    reg_dump_unit #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .SR        (SR),
        .Rdata     (Rdata),
        .busy      (busy),
        .done      (done),
        .stream    (stream_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Rdata = rf[SR];

    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_val(input logic [2:0] idx);
        if (beef_written && idx == 3'd5) return 16'hBEEF;
        return 16'h1000 + {13'd0, idx};
    endfunction

    // Runs one dump from the current cycle and checks the word sequence,
    // the done pulse and the return to idle.
    task automatic dump(input logic [2:0] f, input logic [2:0] l, input bit rnd,
                        input bit inject, input int exp_n);
        int         n;
        int         dones;
        int         cyc;
        bit         injected;
        logic [2:0] exp_idx;
        n        = 0;
        dones    = 0;
        cyc      = 0;
        injected = 0;
        exp_idx  = f;
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        stream_if.out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (dones == 0 && cyc < 300) begin
            stream_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stream_if.out_valid) begin
                check("dump_idx",  {29'd0, stream_if.out_idx}, {29'd0, exp_idx});
                check("dump_data", {16'd0, stream_if.out_data}, {16'd0, exp_val(exp_idx)});
                if (inject && !injected && exp_idx == 3'd2) begin
                    start        = 1'b1;
                    first_reg    = 3'd4;
                    we           = 1'b1;
                    wa           = 3'd5;
                    wd           = 16'hBEEF;
                    injected     = 1;
                    beef_written = 1;
                end
                if (stream_if.out_ready) begin
                    n++;
                    exp_idx = exp_idx + 3'd1;
                end
            end
            if (done) begin
                dones++;
                check("done_no_valid", {31'd0, stream_if.out_valid}, 32'd0);
            end
            tick();
            start = 1'b0;
            we    = 1'b0;
            cyc++;
        end
        check("dump_words", n, exp_n);
        check("dump_dones", dones, 1);
        check("after_done", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        bit vexp;
        logic [2:0] idx;
        checks       = 0;
        errors       = 0;
        beef_written = 0;
        reset        = 1'b1;
        start        = 1'b0;
        first_reg    = 3'd0;
        last_reg     = 3'd0;
        we           = 1'b0;
        wa           = 3'd0;
        wd           = 16'd0;
        stream_if.out_ready = 1'b0;

        // 1: reset values, preload the file while held in reset
        #1 reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, stream_if.out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_sr",    {29'd0, SR}, 32'd0);
        check("rst_data",  {16'd0, stream_if.out_data}, 32'd0);
        check("rst_idx",   {29'd0, stream_if.out_idx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            we = 1'b1;
            wa = 3'(i);
            wd = 16'h1000 + 16'(i);
            tick();
        end
        we = 1'b0;
        check("rst_hold_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", {31'd0, stream_if.out_valid}, 32'd0);
            check("idle_busy",  {31'd0, busy}, 32'd0);
            check("idle_done",  {31'd0, done}, 32'd0);
        end

        // 2: full dump, exact cycle timing with ready tied high
        first_reg = 3'd0;
        last_reg  = 3'd7;
        stream_if.out_ready = 1'b1;
        start = 1'b1;
        check("t2_c0_busy", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            vexp = (c % 2 == 0) && (c >= 2) && (c <= 16);
            check("t2_valid", {31'd0, stream_if.out_valid}, {31'd0, vexp});
            check("t2_done",  {31'd0, done}, {31'd0, (c == 17)});
            check("t2_busy",  {31'd0, busy}, {31'd0, (c <= 17)});
            if (c % 2 == 1 && c <= 15) begin
                check("t2_sr", {29'd0, SR}, 32'((c - 1) / 2));
            end
            if (vexp) begin
                idx = 3'((c - 2) / 2);
                check("t2_idx",  {29'd0, stream_if.out_idx}, {29'd0, idx});
                check("t2_data", {16'd0, stream_if.out_data}, {16'd0, 16'h1000 + {13'd0, idx}});
            end
            tick();
        end

        // 3: same dump with a randomly stalling consumer
        dump(3'd0, 3'd7, 1'b1, 1'b0, 8);

        // 4: wrapping range and single-register range
        dump(3'd6, 3'd1, 1'b0, 1'b0, 4);
        dump(3'd3, 3'd3, 1'b0, 1'b0, 1);

        // 5: start pulse while busy is ignored; write to R5 before its READ shows up
        dump(3'd0, 3'd7, 1'b0, 1'b1, 8);

        // 6: asynchronous reset during SEND of word 3
        tick();
        first_reg = 3'd0;
        last_reg  = 3'd7;
        stream_if.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(stream_if.out_valid && stream_if.out_idx == 3'd3) && cyc < 50) begin
            tick();
            cyc++;
        end
        check("t6_reach_w3", {31'd0, (stream_if.out_valid && stream_if.out_idx == 3'd3)}, 32'd1);
        check("t6_w3_data", {16'd0, stream_if.out_data}, 32'h1003);
        stream_if.out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t6_valid", {31'd0, stream_if.out_valid}, 32'd0);
        check("t6_busy",  {31'd0, busy}, 32'd0);
        check("t6_done",  {31'd0, done}, 32'd0);
        check("t6_data",  {16'd0, stream_if.out_data}, 32'd0);
        check("t6_sr",    {29'd0, SR}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_hold_done", {30'd0, done, busy}, 32'd0);
        end
        reset = 1'b1;
        tick();
        check("t6_rel_done", {31'd0, done}, 32'd0);
        dump(3'd2, 3'd4, 1'b0, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
